// File: rtl/if_stage.sv
// rtl/if_stage.sv - instruction-fetch stage driving the IF->ID bus (optional fetch counter: IF_PERF_CNT_EN)
module if_stage #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2,
    parameter logic [31:0] NOP_INST   = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        stall,
    output logic [63:0] if_id_bus_out,
    output logic [31:0] fetch_cnt
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int OW = CW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
    localparam logic [OW-1:0] DEPTH_O = OW'(FIFO_DEPTH);
    localparam logic [63:0]   BUBBLE  = {NOP_INST, 32'h0};

    typedef enum logic {S_RUN, S_DRAIN} state_e;

    state_e        state_q, state_d;
    logic [31:0]   pc_q, pc_d;
    logic [CW-1:0] inflight_q, inflight_d;
    logic [CW-1:0] drop_cnt_q, drop_cnt_d;
    logic [63:0]   bus_q, bus_d;

    // Buffered {inst,pc} words waiting for ID
    logic [63:0]   fifo_mem_q [FIFO_DEPTH];
    logic [CW-1:0] fifo_wr_q, fifo_wr_d, fifo_rd_q, fifo_rd_d;
    // Addresses of granted, not yet answered requests, in issue order
    logic [31:0]   pcq_mem_q [FIFO_DEPTH];
    logic [CW-1:0] pcq_wr_q, pcq_wr_d, pcq_rd_q, pcq_rd_d;

    logic [CW-1:0] fifo_count;
    logic [OW-1:0] occupancy;
    logic          fifo_empty, fifo_full;
    logic          grant, rsp_drop, rsp_accept, fifo_push, fifo_pop, load_valid;
    logic [63:0]   rsp_word;

    assign fifo_count = fifo_wr_q - fifo_rd_q;
    assign fifo_empty = (fifo_count == '0);
    assign fifo_full  = (fifo_count == DEPTH_C);
    assign occupancy  = {1'b0, inflight_q} + {1'b0, fifo_count};
    assign imem_req   = rst_n && !redirect_valid && (occupancy < DEPTH_O);
    assign imem_addr  = pc_q;
    assign grant      = imem_req && imem_gnt;
    assign rsp_drop   = imem_rvalid && (redirect_valid || (state_q == S_DRAIN));
    assign rsp_accept = imem_rvalid && !rsp_drop;
    assign rsp_word   = {imem_rdata, pcq_mem_q[pcq_rd_q[AW-1:0]]};
    assign fifo_pop   = !redirect_valid && !stall && !fifo_empty;
    assign fifo_push  = rsp_accept && (stall || !fifo_empty);

    // Next-state: pc, outstanding/drop counters, queues, output word, FSM
    always_comb begin
        pc_d       = pc_q;
        inflight_d = inflight_q + CW'(grant) - CW'(imem_rvalid);
        drop_cnt_d = drop_cnt_q;
        bus_d      = bus_q;
        load_valid = 1'b0;
        fifo_wr_d  = fifo_wr_q + CW'(fifo_push);
        fifo_rd_d  = fifo_rd_q + CW'(fifo_pop);
        pcq_wr_d   = pcq_wr_q + CW'(grant);
        pcq_rd_d   = pcq_rd_q + CW'(rsp_accept);
        if (grant) begin
            pc_d = pc_q + 32'd4;
        end
        if (redirect_valid) begin
            // Everything still in flight becomes stale; no grant can happen this cycle
            pc_d       = redirect_pc & 32'hFFFF_FFFC;
            drop_cnt_d = inflight_q - CW'(imem_rvalid);
            bus_d      = BUBBLE;
            fifo_wr_d  = '0;
            fifo_rd_d  = '0;
            pcq_wr_d   = '0;
            pcq_rd_d   = '0;
        end else begin
            if (rsp_drop) begin
                drop_cnt_d = drop_cnt_q - CW'(1);
            end
            if (!stall) begin
                if (!fifo_empty) begin
                    bus_d      = fifo_mem_q[fifo_rd_q[AW-1:0]];
                    load_valid = 1'b1;
                end else if (rsp_accept) begin
                    bus_d      = rsp_word;
                    load_valid = 1'b1;
                end else begin
                    bus_d      = BUBBLE;
                end
            end
        end
        state_d = (drop_cnt_d != '0) ? S_DRAIN : S_RUN;
    end

    // Control and datapath registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= S_RUN;
            pc_q       <= RESET_PC;
            inflight_q <= '0;
            drop_cnt_q <= '0;
            bus_q      <= BUBBLE;
            fifo_wr_q  <= '0;
            fifo_rd_q  <= '0;
            pcq_wr_q   <= '0;
            pcq_rd_q   <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            inflight_q <= inflight_d;
            drop_cnt_q <= drop_cnt_d;
            bus_q      <= bus_d;
            fifo_wr_q  <= fifo_wr_d;
            fifo_rd_q  <= fifo_rd_d;
            pcq_wr_q   <= pcq_wr_d;
            pcq_rd_q   <= pcq_rd_d;
        end
    end

    // Queue storage writes (contents need no reset, pointers gate validity)
    always_ff @(posedge clk) begin
        if (fifo_push) begin
            fifo_mem_q[fifo_wr_q[AW-1:0]] <= rsp_word;
        end
        if (grant) begin
            pcq_mem_q[pcq_wr_q[AW-1:0]] <= pc_q;
        end
    end

    // The request capacity rule must make a full-FIFO push impossible
    always @(posedge clk) begin
        if (rst_n) begin
            assert (!(fifo_push && fifo_full && !fifo_pop));
        end
    end

    assign if_id_bus_out = bus_q;

`ifdef IF_PERF_CNT_EN
    logic [31:0] fetch_cnt_q;

    // Count words actually delivered to ID
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fetch_cnt_q <= 32'h0;
        end else if (load_valid) begin
            fetch_cnt_q <= fetch_cnt_q + 32'd1;
        end
    end

    assign fetch_cnt = fetch_cnt_q;
`else
    logic unused_load_valid;

    assign unused_load_valid = load_valid;
    assign fetch_cnt         = 32'h0;
`endif

endmodule

// File: tb/tb_if_stage.sv
// tb/tb_if_stage.sv - directed self-checking bench for if_stage
module tb_if_stage;
    localparam logic [31:0] NOP    = 32'h0000_0013;
    localparam logic [31:0] MASK   = 32'hA5A5_0000;
    localparam logic [63:0] BUBBLE = {NOP, 32'h0};
`ifdef IF_PERF_CNT_EN
    localparam logic [31:0] EXP_CNT = 32'd10;
`else
    localparam logic [31:0] EXP_CNT = 32'd0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt = 1'b1;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = 32'h0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        stall = 1'b0;
    logic [63:0] if_id_bus_out;
    logic [31:0] fetch_cnt;

    int n_checks = 0;
    int n_fail   = 0;
    int lat      = 1;
    int cyc      = 0;
    logic [31:0] mq_addr[$];
    int          mq_due[$];

    if_stage #(.RESET_PC(32'h0), .FIFO_DEPTH(2), .NOP_INST(NOP)) dut (
        .clk(clk), .rst_n(rst_n),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .stall(stall),
        .if_id_bus_out(if_id_bus_out), .fetch_cnt(fetch_cnt)
    );

    always #5 clk = ~clk;

    // Memory model: answers each grant in order, lat cycles later, rdata = addr ^ MASK
    always @(posedge clk) begin
        if (!rst_n) begin
            mq_addr.delete();
            mq_due.delete();
        end else begin
            if (imem_rvalid && mq_addr.size() > 0) begin
                void'(mq_addr.pop_front());
                void'(mq_due.pop_front());
            end
            if (imem_req && imem_gnt) begin
                mq_addr.push_back(imem_addr);
                mq_due.push_back(cyc + lat);
            end
        end
        cyc++;
        #1;
        if (mq_addr.size() > 0 && mq_due[0] <= cyc) begin
            imem_rvalid = 1'b1;
            imem_rdata  = mq_addr[0] ^ MASK;
        end else begin
            imem_rvalid = 1'b0;
            imem_rdata  = 32'h0;
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] word(input logic [31:0] pc);
        return {pc ^ MASK, pc};
    endfunction

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        redirect_valid = 1'b0;
        stall = 1'b0;
        imem_gnt = 1'b1;
        tick();
        tick();
    endtask

    task automatic wait_word();
        for (int i = 0; i < 12 && if_id_bus_out === BUBBLE; i++) tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        // Reset and release
        lat = 1;
        do_reset();
        check("rst_bus", if_id_bus_out, BUBBLE);
        check("rst_req", imem_req, 1'b0);
        check("rst_cnt", fetch_cnt, 32'h0);
        rst_n = 1'b1;
        #1;
        check("rel_req", imem_req, 1'b1);
        check("rel_addr", imem_addr, 32'h0);

        // Streaming: one word per cycle, 1 cycle after rvalid
        tick();
        tick(); check("stream_0", if_id_bus_out, word(32'h0));
        tick(); check("stream_4", if_id_bus_out, word(32'h4));
        tick(); check("stream_8", if_id_bus_out, word(32'h8));

        // Stall: bus holds, FIFO fills, requests stop
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("stall_hold", if_id_bus_out, word(32'h8));
            check("stall_req", imem_req, 1'b0);
        end
        stall = 1'b0;
        tick(); check("unstall_12", if_id_bus_out, word(32'hC));
        tick(); check("unstall_16", if_id_bus_out, word(32'h10));
        tick(); check("unstall_20", if_id_bus_out, word(32'h14));

        // Redirect with two requests in flight
        lat = 3;
        do_reset();
        rst_n = 1'b1;
        tick();
        tick();
        check("rd_full_req", imem_req, 1'b0);
        redirect_valid = 1'b1;
        redirect_pc = 32'h100;
        tick();
        check("rd_bubble", if_id_bus_out, BUBBLE);
        check("rd_addr", imem_addr, 32'h100);
        redirect_valid = 1'b0;
        #1;
        check("rd_cap_req", imem_req, 1'b0);
        tick();
        check("rd_drop_bus", if_id_bus_out, BUBBLE);
        check("rd_req", imem_req, 1'b1);
        check("rd_req_addr", imem_addr, 32'h100);
        wait_word();
        check("rd_first", if_id_bus_out, word(32'h100));

        // Redirect during stall with a response in the same cycle, misaligned target
        lat = 1;
        do_reset();
        rst_n = 1'b1;
        tick();
        tick(); check("rs_pre", if_id_bus_out, word(32'h0));
        stall = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc = 32'h203;
        tick();
        check("rs_bubble", if_id_bus_out, BUBBLE);
        check("rs_addr", imem_addr, 32'h200);
        redirect_valid = 1'b0;
        #1;
        check("rs_req", imem_req, 1'b1);
        stall = 1'b0;
        wait_word();
        check("rs_first", if_id_bus_out, word(32'h200));

        // PC wrap-around
        redirect_valid = 1'b1;
        redirect_pc = 32'hFFFF_FFFC;
        tick();
        redirect_valid = 1'b0;
        wait_word();
        check("wrap_top", if_id_bus_out, word(32'hFFFF_FFFC));
        tick();
        check("wrap_zero", if_id_bus_out, word(32'h0));

        // Delivered-word counter: 10 words then bubbles; request held without grant
        lat = 1;
        do_reset();
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) tick();
        imem_gnt = 1'b0;
        tick();
        check("cnt_last", if_id_bus_out, word(32'h24));
        tick();
        check("cnt_bubble", if_id_bus_out, BUBBLE);
        check("hold_req", imem_req, 1'b1);
        check("hold_addr", imem_addr, 32'h28);
        tick();
        tick();
        check("hold_addr2", imem_addr, 32'h28);
        check("fetch_cnt", fetch_cnt, EXP_CNT);
        imem_gnt = 1'b1;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
